// File: rtl/riscv_core_arb4_if.sv
// riscv_core_arb4_if: request/grant bundle between four requesters and the
// shared-resource arbiter. Requesters drive the master side; the arbiter
// sits on the slave side.
interface riscv_core_arb4_if;
    logic [3:0] i_arb_req;
    logic       i_arb_done;
    logic [3:0] o_arb_gnt;
    logic [1:0] o_arb_sel;
    logic       o_arb_busy;
    logic       o_arb_timeout;

    modport master (
        output i_arb_req,
        output i_arb_done,
        input  o_arb_gnt,
        input  o_arb_sel,
        input  o_arb_busy,
        input  o_arb_timeout
    );

    modport slave (
        input  i_arb_req,
        input  i_arb_done,
        output o_arb_gnt,
        output o_arb_sel,
        output o_arb_busy,
        output o_arb_timeout
    );
endinterface

// File: rtl/riscv_core_arb4.sv
// riscv_core_arb4: 4-way round-robin arbiter for a shared datapath resource.
// Ownership is held until the owner signals done; the next winner is granted
// on the following cycle with no bubble. All outputs are registered.
// Optional watchdog: define RISCV_CORE_ARB_WATCHDOG_EN to force a release after
// TIMEOUT_CYCLES owned cycles without done (o_arb_timeout pulses once).
module riscv_core_arb4 #(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    riscv_core_arb4_if.slave    arb
);

    if (XLEN < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
        $error("riscv_core_arb4: XLEN or TIMEOUT_CYCLES out of range");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;

    logic       wd_expire;
    logic [2:0] pick;

`ifdef RISCV_CORE_ARB_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt_q, wd_cnt_d;

    // Limit is reached on the owned cycle whose increment would hit TIMEOUT_CYCLES.
    assign wd_expire = (wd_cnt_q == WD_LAST);
`else
    assign wd_expire = 1'b0;
`endif

    // Round-robin search: base+1, base+2, base+3, base. Since base is the last
    // owner, a releasing owner naturally ranks last. Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!res[2] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign pick = rr_pick(arb.i_arb_req, ptr_q);

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
`ifdef RISCV_CORE_ARB_WATCHDOG_EN
        wd_cnt_d  = wd_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (pick[2]) begin
                    state_d = ST_OWNED;
                    ptr_d   = pick[1:0];
                    sel_d   = pick[1:0];
                    gnt_d   = 4'b0001 << pick[1:0];
                    busy_d  = 1'b1;
`ifdef RISCV_CORE_ARB_WATCHDOG_EN
                    wd_cnt_d = '0;
`endif
                end
            end
            ST_OWNED: begin
                if (arb.i_arb_done || wd_expire) begin
                    timeout_d = !arb.i_arb_done;
                    if (pick[2]) begin
                        ptr_d  = pick[1:0];
                        sel_d  = pick[1:0];
                        gnt_d  = 4'b0001 << pick[1:0];
                        busy_d = 1'b1;
`ifdef RISCV_CORE_ARB_WATCHDOG_EN
                        wd_cnt_d = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end else begin
`ifdef RISCV_CORE_ARB_WATCHDOG_EN
                    wd_cnt_d = wd_cnt_q + 16'd1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd3;
            gnt_q     <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef RISCV_CORE_ARB_WATCHDOG_EN
            wd_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
`ifdef RISCV_CORE_ARB_WATCHDOG_EN
            wd_cnt_q  <= wd_cnt_d;
`endif
        end
    end

    assign arb.o_arb_gnt     = gnt_q;
    assign arb.o_arb_sel     = sel_q;
    assign arb.o_arb_busy    = busy_q;
    assign arb.o_arb_timeout = timeout_q;

endmodule
